// File: rtl/tile_fetcher.sv
// Avalon pipelined read master that streams a ROWS x ROW_WORDS tile into a FIFO.
// Reads are credit-limited so pending responses always fit in the FIFO.
module tile_fetcher #(
  parameter int ROW_WORDS   = 16,
  parameter int ROWS        = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int USEDW_W     = 7,
  parameter int MAX_PENDING = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [15:0]        stride_in,
  input  logic [31:0]        addr_in,
  input  logic               start,
  output logic               running_out,
  output logic [31:0]        fifo_data,
  output logic               fifo_write,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic [31:0]        master_address,
  output logic               master_read,
  input  logic [31:0]        master_read_data,
  input  logic               master_read_data_valid,
  input  logic               master_wait_request
);

  localparam int TOTAL = ROWS * ROW_WORDS;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int PW    = $clog2(MAX_PENDING + 1);
  localparam int COLW  = $clog2(ROW_WORDS);
  localparam logic [31:0] ROW_REWIND = 32'(4 * (ROW_WORDS - 1));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     stride_q, stride_d;
  logic [COLW-1:0] col_q, col_d;
  logic [CW-1:0]   tx_q, tx_d;
  logic [CW-1:0]   rx_q, rx_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            hold_q, hold_d;

  logic [USEDW_W:0] inflight;
  logic             credit_ok;
  logic             accept;

  // Widened sum so usedw + pending cannot wrap before the depth compare.
  assign inflight  = {1'b0, fifo_usedw} + (USEDW_W + 1)'(pending_q);
  assign credit_ok = (pending_q < PW'(MAX_PENDING)) &&
                     (inflight < (USEDW_W + 1)'(FIFO_DEPTH));

  assign running_out    = (state_q != IDLE);
  assign master_read    = (state_q == ISSUE) && (hold_q || credit_ok);
  assign accept         = master_read && !master_wait_request;
  assign master_address = addr_q;
  assign fifo_write     = running_out && master_read_data_valid;
  assign fifo_data      = master_read_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      col_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      pending_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      col_q     <= col_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    col_d     = col_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    pending_d = pending_q;
    // A request stalled by wait_request must stay up even if credit drops.
    hold_d    = master_read && master_wait_request;

    if (accept && !fifo_write) begin
      pending_d = pending_q + PW'(1);
    end else if (!accept && fifo_write) begin
      pending_d = pending_q - PW'(1);
    end

    if (fifo_write) begin
      rx_d = rx_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = addr_in;
          stride_d  = stride_in;
          col_d     = '0;
          tx_d      = '0;
          rx_d      = '0;
          pending_d = '0;
          hold_d    = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          tx_d  = tx_q + CW'(1);
          col_d = col_q + COLW'(1);
          if (col_q == {COLW{1'b1}}) begin
            addr_d = addr_q + {16'b0, stride_q} - ROW_REWIND;
          end else begin
            addr_d = addr_q + 32'd4;
          end
          if (tx_q == CW'(TOTAL - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
      end
    endcase

    if (fifo_write && (rx_q == CW'(TOTAL - 1))) begin
      state_d = IDLE;
    end
  end

endmodule
